// File: rtl/decade_timer_pkg.sv
// Shared constants for the decade timer and event counter: default widths,
// the power-of-ten table and the FSM state encoding.
package decade_timer_pkg;

    localparam int unsigned DEF_MAX_EXP = 9;
    localparam int unsigned DEF_CNT_W   = 30;
    localparam int unsigned BASE_W      = 7;
    localparam int unsigned EXP_W       = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // 10^e for e = 0..9; out-of-range selectors are never loaded, so they return 1
    function automatic logic [DEF_CNT_W-1:0] pow10(input logic [EXP_W-1:0] e);
        logic [DEF_CNT_W-1:0] r;
        case (e)
            4'd0:    r = DEF_CNT_W'(1);
            4'd1:    r = DEF_CNT_W'(10);
            4'd2:    r = DEF_CNT_W'(100);
            4'd3:    r = DEF_CNT_W'(1000);
            4'd4:    r = DEF_CNT_W'(10000);
            4'd5:    r = DEF_CNT_W'(100000);
            4'd6:    r = DEF_CNT_W'(1000000);
            4'd7:    r = DEF_CNT_W'(10000000);
            4'd8:    r = DEF_CNT_W'(100000000);
            4'd9:    r = DEF_CNT_W'(1000000000);
            default: r = DEF_CNT_W'(1);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/decade_prescaler.sv
// Inner tick counter: divides enabled ticks by 10^exp_sel and emits one
// unit_tick per completed mantissa unit.
module decade_prescaler
    import decade_timer_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [EXP_W-1:0] i_exp_sel,
    output logic             o_unit_tick_c
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_term;
    logic             w_at_term;

    assign w_at_term     = (r_cnt == r_term);
    assign o_unit_tick_c = i_en && w_at_term;

    // Terminal count is captured once at load so the compare never sees a multiplier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_term <= '0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_term <= CNT_W'(pow10(i_exp_sel)) - CNT_W'(1);
        end else if (i_en) begin
            r_cnt  <= w_at_term ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/decade_timer.sv
// One-shot delay timer: waits base x 10^exponent enabled ticks after start,
// then pulses done. Rejects out-of-range exponents with an err pulse.
module decade_timer
    import decade_timer_pkg::*;
#(
    parameter int unsigned MAX_EXP = DEF_MAX_EXP,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              start,
    input  logic              abort,
    input  logic [BASE_W-1:0] base,
    input  logic [EXP_W-1:0]  exponent,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [BASE_W-1:0] rem_base
);

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [BASE_W-1:0] r_rem;

    logic w_start_ok;
    logic w_exp_ok;
    logic w_base_nz;
    logic w_load;
    logic w_run_en;
    logic w_unit_tick;

    assign w_start_ok = (r_state == ST_IDLE) && start && !abort;
    assign w_exp_ok   = (exponent <= EXP_W'(MAX_EXP));
    assign w_base_nz  = (base != '0);
    assign w_load     = w_start_ok && w_exp_ok && w_base_nz;
    assign w_run_en   = (r_state == ST_RUN) && en && !abort;

    decade_prescaler #(
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_en          (w_run_en),
        .i_clr         (w_load),
        .i_exp_sel     (exponent),
        .o_unit_tick_c (w_unit_tick)
    );

    // Control FSM; done/err are single-cycle registered pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rem   <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        if (!w_exp_ok) begin
                            r_err <= 1'b1;
                        end else if (!w_base_nz) begin
                            r_done <= 1'b1;
                        end else begin
                            r_rem   <= base;
                            r_busy  <= 1'b1;
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_rem   <= '0;
                    end else if (w_unit_tick) begin
                        r_rem <= r_rem - BASE_W'(1);
                        if (r_rem == BASE_W'(1)) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign rem_base = r_rem;

endmodule
